// File: rtl/arith_seq_if.sv
// Handshake and micro-op bundle between the order decoder, the arithmetic
// unit datapath and the arith_seq program sequencer.
interface arith_seq_if #(
    parameter int SHIFT_W = 3
) ();
    // order decoder / processing unit side
    logic               clear_a_from_pu;
    logic               start_from_op;
    logic [2:0]         op_from_op;
    logic [SHIFT_W-1:0] shift_len_from_io;
    // AU status levels
    logic               sign_a_from_au;
    logic               sign_b_from_au;
    logic               carry_out_from_au;
    logic               reg_c_lsb_from_au;
    logic               reg_b_msb_from_au;
    // handshake back to the order decoder
    logic               busy_to_op;
    logic               au_answer_to_op;
    logic               overflow_to_op;
    // AU control
    logic               result_sign_to_au;
    logic               do_not_a_to_au;
    logic               do_not_b_to_au;
    logic               do_clear_b_to_au;
    logic               do_sum_to_au;
    logic               do_and_to_au;
    logic               do_set_c_lsb_to_au;
    logic               do_left_shift_b_to_au;
    logic               do_left_shift_c_to_au;
    logic               do_right_shift_bc_to_au;
    logic               do_move_b_to_c_to_au;
    logic               do_move_c_to_b_to_au;

    // environment side: drives orders and AU status, observes the sequencer
    modport master (
        output clear_a_from_pu, start_from_op, op_from_op, shift_len_from_io,
        output sign_a_from_au, sign_b_from_au, carry_out_from_au,
        output reg_c_lsb_from_au, reg_b_msb_from_au,
        input  busy_to_op, au_answer_to_op, overflow_to_op, result_sign_to_au,
        input  do_not_a_to_au, do_not_b_to_au, do_clear_b_to_au, do_sum_to_au,
        input  do_and_to_au, do_set_c_lsb_to_au, do_left_shift_b_to_au,
        input  do_left_shift_c_to_au, do_right_shift_bc_to_au,
        input  do_move_b_to_c_to_au, do_move_c_to_b_to_au
    );

    // sequencer side
    modport slave (
        input  clear_a_from_pu, start_from_op, op_from_op, shift_len_from_io,
        input  sign_a_from_au, sign_b_from_au, carry_out_from_au,
        input  reg_c_lsb_from_au, reg_b_msb_from_au,
        output busy_to_op, au_answer_to_op, overflow_to_op, result_sign_to_au,
        output do_not_a_to_au, do_not_b_to_au, do_clear_b_to_au, do_sum_to_au,
        output do_and_to_au, do_set_c_lsb_to_au, do_left_shift_b_to_au,
        output do_left_shift_c_to_au, do_right_shift_bc_to_au,
        output do_move_b_to_c_to_au, do_move_c_to_b_to_au
    );
endinterface

// File: rtl/arith_seq.sv
// Local program sequencer for the arithmetic unit. One one-hot FSM plus a
// shared iteration counter issues the AU micro-op pulses for add, sub, mul,
// div, and, and variable-length left shift, reports completion/overflow to
// the order decoder and keeps the sign of the last result.
module arith_seq #(
    parameter int WIDTH   = 30,
    parameter int SHIFT_W = 3
) (
    input logic        clk,
    input logic        resetn,
    arith_seq_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int CMP_W = (CNT_W > SHIFT_W) ? CNT_W : SHIFT_W;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_MUL   = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_AND   = 3'd4;
    localparam logic [2:0] OP_SHIFT = 3'd5;

    typedef enum logic [7:0] {
        S_IDLE   = 8'b0000_0001,
        S_PREP   = 8'b0000_0010,
        S_EXEC   = 8'b0000_0100,
        S_FIX    = 8'b0000_1000,
        S_LOOP_A = 8'b0001_0000,
        S_LOOP_B = 8'b0010_0000,
        S_WB     = 8'b0100_0000,
        S_ERR    = 8'b1000_0000
    } state_t;

    state_t             state_r;
    state_t             next_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [2:0]         op_r;
    logic [SHIFT_W-1:0] shift_len_r;
    logic               sign_r;

    logic               cnt_clr_s;
    logic               cnt_inc_s;
    logic               sign_ld_s;
    logic               sign_val_s;
    logic               op_ld_s;
    logic               iter_last_s;
    logic               shift_last_s;

    // mul/div leave the loop on the last of WIDTH iterations; shift after shift_len
    assign iter_last_s  = (cnt_r == CNT_W'(WIDTH - 1));
    assign shift_last_s = (CMP_W'(cnt_r) == (CMP_W'(shift_len_r) - CMP_W'(1)));

    assign bus.busy_to_op        = (state_r != S_IDLE);
    assign bus.result_sign_to_au = sign_r;

    // next-state selection and combinational micro-op decode
    always_comb begin
        next_s                      = state_r;
        cnt_clr_s                   = 1'b0;
        cnt_inc_s                   = 1'b0;
        sign_ld_s                   = 1'b0;
        sign_val_s                  = sign_r;
        op_ld_s                     = 1'b0;
        bus.au_answer_to_op         = 1'b0;
        bus.overflow_to_op          = 1'b0;
        bus.do_not_a_to_au          = 1'b0;
        bus.do_not_b_to_au          = 1'b0;
        bus.do_clear_b_to_au        = 1'b0;
        bus.do_sum_to_au            = 1'b0;
        bus.do_and_to_au            = 1'b0;
        bus.do_set_c_lsb_to_au      = 1'b0;
        bus.do_left_shift_b_to_au   = 1'b0;
        bus.do_left_shift_c_to_au   = 1'b0;
        bus.do_right_shift_bc_to_au = 1'b0;
        bus.do_move_b_to_c_to_au    = 1'b0;
        bus.do_move_c_to_b_to_au    = 1'b0;

        if (bus.clear_a_from_pu) begin
            // abort: silence everything, drop to IDLE, keep the result sign
            next_s    = S_IDLE;
            cnt_clr_s = 1'b1;
        end else begin
            case (state_r)
                S_IDLE: begin
                    cnt_clr_s = 1'b1;
                    if (bus.start_from_op) begin
                        case (bus.op_from_op)
                            OP_ADD, OP_AND: begin
                                op_ld_s = 1'b1;
                                next_s  = S_EXEC;
                            end
                            OP_SUB, OP_MUL, OP_DIV: begin
                                op_ld_s = 1'b1;
                                next_s  = S_PREP;
                            end
                            OP_SHIFT: begin
                                op_ld_s = 1'b1;
                                if (bus.shift_len_from_io == {SHIFT_W{1'b0}}) begin
                                    next_s = S_WB;
                                end else begin
                                    next_s = S_LOOP_B;
                                end
                            end
                            default: begin
                                next_s = S_IDLE;
                            end
                        endcase
                    end else begin
                        next_s = S_IDLE;
                    end
                end
                S_PREP: begin
                    case (op_r)
                        OP_SUB: begin
                            bus.do_not_a_to_au = 1'b1;
                            next_s             = S_EXEC;
                        end
                        OP_MUL: begin
                            bus.do_clear_b_to_au = 1'b1;
                            sign_ld_s            = 1'b1;
                            sign_val_s           = bus.sign_a_from_au ^ bus.sign_b_from_au;
                            next_s               = S_LOOP_A;
                        end
                        OP_DIV: begin
                            bus.do_not_a_to_au = 1'b1;
                            sign_ld_s          = 1'b1;
                            sign_val_s         = bus.sign_a_from_au ^ bus.sign_b_from_au;
                            next_s             = S_EXEC;
                        end
                        default: begin
                            next_s = S_IDLE;
                        end
                    endcase
                end
                S_EXEC: begin
                    case (op_r)
                        OP_ADD: begin
                            if (bus.carry_out_from_au) begin
                                next_s = S_ERR;
                            end else begin
                                bus.do_sum_to_au = 1'b1;
                                next_s           = S_WB;
                            end
                        end
                        OP_SUB: begin
                            // no carry means the result went negative: recomplement in FIX
                            sign_ld_s  = 1'b1;
                            sign_val_s = bus.sign_b_from_au & ~bus.carry_out_from_au;
                            if (bus.carry_out_from_au) begin
                                bus.do_sum_to_au = 1'b1;
                                next_s           = S_WB;
                            end else begin
                                bus.do_not_a_to_au = 1'b1;
                                bus.do_not_b_to_au = 1'b1;
                                next_s             = S_FIX;
                            end
                        end
                        OP_DIV: begin
                            if (bus.carry_out_from_au) begin
                                next_s = S_ERR;
                            end else begin
                                next_s = S_LOOP_A;
                            end
                        end
                        OP_AND: begin
                            bus.do_and_to_au = 1'b1;
                            next_s           = S_WB;
                        end
                        default: begin
                            next_s = S_IDLE;
                        end
                    endcase
                end
                S_FIX: begin
                    bus.do_sum_to_au = 1'b1;
                    next_s           = S_WB;
                end
                S_LOOP_A: begin
                    case (op_r)
                        OP_MUL: begin
                            bus.do_sum_to_au = bus.reg_c_lsb_from_au;
                            next_s           = S_LOOP_B;
                        end
                        OP_DIV: begin
                            bus.do_left_shift_b_to_au = 1'b1;
                            bus.do_left_shift_c_to_au = 1'b1;
                            next_s                    = S_LOOP_B;
                        end
                        default: begin
                            next_s = S_IDLE;
                        end
                    endcase
                end
                S_LOOP_B: begin
                    cnt_inc_s = 1'b1;
                    case (op_r)
                        OP_MUL: begin
                            bus.do_right_shift_bc_to_au = 1'b1;
                            next_s = iter_last_s ? S_WB : S_LOOP_A;
                        end
                        OP_DIV: begin
                            bus.do_sum_to_au       = bus.carry_out_from_au ^ bus.reg_b_msb_from_au;
                            bus.do_set_c_lsb_to_au = bus.carry_out_from_au ^ bus.reg_b_msb_from_au;
                            next_s = iter_last_s ? S_WB : S_LOOP_A;
                        end
                        OP_SHIFT: begin
                            bus.do_left_shift_c_to_au = 1'b1;
                            next_s = shift_last_s ? S_WB : S_LOOP_B;
                        end
                        default: begin
                            next_s = S_IDLE;
                        end
                    endcase
                end
                S_WB: begin
                    bus.au_answer_to_op = 1'b1;
                    next_s              = S_IDLE;
                    case (op_r)
                        OP_ADD, OP_SUB, OP_MUL: begin
                            bus.do_move_b_to_c_to_au = 1'b1;
                        end
                        OP_DIV, OP_AND: begin
                            bus.do_move_c_to_b_to_au = 1'b1;
                        end
                        default: begin
                            bus.do_move_b_to_c_to_au = 1'b0;
                        end
                    endcase
                end
                S_ERR: begin
                    bus.au_answer_to_op = 1'b1;
                    bus.overflow_to_op  = 1'b1;
                    next_s              = S_IDLE;
                end
                default: begin
                    // corrupted one-hot vector: recover to IDLE
                    next_s = S_IDLE;
                end
            endcase
        end
    end

    // state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // shared iteration counter
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_clr_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_inc_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // order code and shift length captured at accepted start
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_r        <= 3'd0;
            shift_len_r <= {SHIFT_W{1'b0}};
        end else if (op_ld_s) begin
            op_r        <= bus.op_from_op;
            shift_len_r <= bus.shift_len_from_io;
        end else begin
            op_r        <= op_r;
            shift_len_r <= shift_len_r;
        end
    end

    // latched result sign
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sign_r <= 1'b0;
        end else if (sign_ld_s) begin
            sign_r <= sign_val_s;
        end else begin
            sign_r <= sign_r;
        end
    end
endmodule

// File: tb/tb_arith_seq.sv
// Self-checking bench for arith_seq: a vector table of whole orders with
// expected answer cycle, overflow, sign and micro-op pulse counts, a
// scoreboard queue for answers, and hand-written abort/reset sequences.
module tb_arith_seq;
    localparam int WIDTH   = 30;
    localparam int SHIFT_W = 3;
    localparam int NMO     = 11;
    // pulse index: 0 not_a 1 not_b 2 clear_b 3 sum 4 and 5 set_c_lsb
    //              6 lshift_b 7 lshift_c 8 rshift_bc 9 move_b_to_c 10 move_c_to_b

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    arith_seq_if #(.SHIFT_W(SHIFT_W)) bus ();
    arith_seq #(.WIDTH(WIDTH), .SHIFT_W(SHIFT_W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    typedef logic [NMO-1:0][7:0] cnt_t;
    typedef struct {
        logic [2:0] op;
        logic [2:0] len;
        bit         sa;
        bit         sb;
        int         exec_c;      // cycle (after start) at which carry is the EXEC carry
        bit         carry;
        bit         loop_carry;  // carry on every other cycle
        bit         bmsb;
        int         clsb_mode;   // 0 low, 1 high on every other LOOP_A, 2 high
        int         lat;         // expected answer cycle
        bit         ovf;
        int         sign;        // 0/1, or 2 meaning unchanged
        cnt_t       cnt;
    } vec_t;
    typedef struct {
        int lat;
        bit ovf;
        bit sign;
    } exp_t;

    exp_t sbq[$];
    vec_t vt[13];
    int   errors = 0;
    int   checks = 0;
    bit   model_sign;

    function automatic cnt_t mc(int na, int nb, int cb, int sm, int an, int sc,
                                int lb, int lc, int rs, int mbc, int mcb);
        cnt_t r;
        r[0] = 8'(na);  r[1] = 8'(nb);  r[2] = 8'(cb);  r[3] = 8'(sm);
        r[4] = 8'(an);  r[5] = 8'(sc);  r[6] = 8'(lb);  r[7] = 8'(lc);
        r[8] = 8'(rs);  r[9] = 8'(mbc); r[10] = 8'(mcb);
        return r;
    endfunction

    function automatic logic [NMO-1:0] pulses();
        return {bus.do_move_c_to_b_to_au, bus.do_move_b_to_c_to_au,
                bus.do_right_shift_bc_to_au, bus.do_left_shift_c_to_au,
                bus.do_left_shift_b_to_au, bus.do_set_c_lsb_to_au,
                bus.do_and_to_au, bus.do_sum_to_au, bus.do_clear_b_to_au,
                bus.do_not_b_to_au, bus.do_not_a_to_au};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic quiet_inputs();
        bus.clear_a_from_pu   = 1'b0;
        bus.start_from_op     = 1'b0;
        bus.op_from_op        = 3'd0;
        bus.shift_len_from_io = 3'd0;
        bus.sign_a_from_au    = 1'b0;
        bus.sign_b_from_au    = 1'b0;
        bus.carry_out_from_au = 1'b0;
        bus.reg_c_lsb_from_au = 1'b0;
        bus.reg_b_msb_from_au = 1'b0;
    endtask

    // Called at a negedge while the DUT is idle; returns at the negedge of
    // the first IDLE cycle after the answer.
    task automatic run_vec(input int idx, input vec_t v);
        int   seen[NMO];
        int   c;
        int   busy_bad;
        int   ovf_n;
        bit   got;
        exp_t e;
        logic [NMO-1:0] p;
        bus.op_from_op        = v.op;
        bus.shift_len_from_io = v.len;
        bus.sign_a_from_au    = v.sa;
        bus.sign_b_from_au    = v.sb;
        bus.start_from_op     = 1'b1;
        e.lat  = v.lat;
        e.ovf  = v.ovf;
        e.sign = (v.sign == 2) ? model_sign : (v.sign == 1);
        sbq.push_back(e);
        if (v.sign != 2) model_sign = (v.sign == 1);
        for (int k = 0; k < NMO; k++) seen[k] = 0;
        c = 0; busy_bad = 0; ovf_n = 0; got = 1'b0;
        while (!got && c < 200) begin
            c++;
            @(posedge clk); #1;
            bus.start_from_op     = 1'b0;
            bus.carry_out_from_au = (c == v.exec_c) ? v.carry : v.loop_carry;
            bus.reg_c_lsb_from_au = (v.clsb_mode == 2) || ((v.clsb_mode == 1) && ((c % 4) == 2));
            bus.reg_b_msb_from_au = v.bmsb;
            @(negedge clk);
            p = pulses();
            for (int k = 0; k < NMO; k++) if (p[k] === 1'b1) seen[k]++;
            if (bus.busy_to_op !== 1'b1) busy_bad++;
            if (bus.overflow_to_op === 1'b1) ovf_n++;
            if (bus.au_answer_to_op === 1'b1) begin
                got = 1'b1;
                e = sbq.pop_front();
                check($sformatf("v%0d_answer_cycle", idx), c, e.lat);
                check($sformatf("v%0d_overflow", idx), int'(bus.overflow_to_op), int'(e.ovf));
                check($sformatf("v%0d_result_sign", idx), int'(bus.result_sign_to_au), int'(e.sign));
            end
        end
        if (!got) begin
            check($sformatf("v%0d_answer_timeout", idx), 0, 1);
            e = sbq.pop_front();
        end
        check($sformatf("v%0d_busy_during_op", idx), busy_bad, 0);
        check($sformatf("v%0d_overflow_pulses", idx), ovf_n, int'(v.ovf));
        for (int k = 0; k < NMO; k++)
            check($sformatf("v%0d_pulse%0d_count", idx, k), seen[k], int'(v.cnt[k]));
        @(posedge clk); #1;
        bus.carry_out_from_au = 1'b0;
        bus.reg_c_lsb_from_au = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d_busy_after", idx), int'(bus.busy_to_op), 0);
        check($sformatf("v%0d_answer_after", idx), int'(bus.au_answer_to_op), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int answers;
        //           op    len  sa sb  exc car lpc bm clm lat ovf sgn counts
        vt[0]  = '{3'd1, 3'd0, 0, 1, 2, 0, 0, 0, 0,  4, 0, 1, mc(2,1,0,1,0,0,0,0,0,1,0)};
        vt[1]  = '{3'd0, 3'd0, 0, 0, 1, 0, 0, 0, 0,  2, 0, 2, mc(0,0,0,1,0,0,0,0,0,1,0)};
        vt[2]  = '{3'd0, 3'd0, 0, 0, 1, 1, 1, 0, 0,  2, 1, 2, mc(0,0,0,0,0,0,0,0,0,0,0)};
        vt[3]  = '{3'd4, 3'd0, 0, 0, 1, 0, 0, 0, 0,  2, 0, 2, mc(0,0,0,0,1,0,0,0,0,0,1)};
        vt[4]  = '{3'd5, 3'd4, 0, 0, 0, 0, 0, 0, 0,  5, 0, 2, mc(0,0,0,0,0,0,0,4,0,0,0)};
        vt[5]  = '{3'd1, 3'd0, 0, 1, 2, 1, 1, 0, 0,  3, 0, 0, mc(1,0,0,1,0,0,0,0,0,1,0)};
        vt[6]  = '{3'd5, 3'd0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 2, mc(0,0,0,0,0,0,0,0,0,0,0)};
        vt[7]  = '{3'd2, 3'd0, 1, 0, 0, 0, 0, 0, 1, 62, 0, 1, mc(0,0,1,15,0,0,0,0,30,1,0)};
        vt[8]  = '{3'd2, 3'd0, 1, 1, 0, 0, 0, 0, 2, 62, 0, 0, mc(0,0,1,30,0,0,0,0,30,1,0)};
        vt[9]  = '{3'd3, 3'd0, 0, 1, 2, 0, 1, 0, 0, 63, 0, 1, mc(1,0,0,30,0,30,30,30,0,0,1)};
        vt[10] = '{3'd3, 3'd0, 1, 1, 2, 1, 1, 0, 0,  3, 1, 0, mc(1,0,0,0,0,0,0,0,0,0,0)};
        vt[11] = '{3'd3, 3'd0, 1, 0, 2, 0, 1, 1, 0, 63, 0, 1, mc(1,0,0,0,0,0,30,30,0,0,1)};
        vt[12] = '{3'd5, 3'd7, 0, 0, 0, 0, 0, 0, 0,  8, 0, 2, mc(0,0,0,0,0,0,0,7,0,0,0)};

        // reset state, with a start held during reset that must be ignored
        quiet_inputs();
        resetn = 1'b0;
        model_sign = 1'b0;
        bus.start_from_op = 1'b1;
        #12;
        check("reset_busy", int'(bus.busy_to_op), 0);
        check("reset_answer", int'(bus.au_answer_to_op), 0);
        check("reset_overflow", int'(bus.overflow_to_op), 0);
        check("reset_result_sign", int'(bus.result_sign_to_au), 0);
        check("reset_pulses", int'(pulses()), 0);
        @(negedge clk);
        check("reset_busy_after_edge", int'(bus.busy_to_op), 0);
        bus.start_from_op = 1'b0;
        resetn = 1'b1;
        @(negedge clk);

        // invalid order codes are ignored
        for (int op = 6; op < 8; op++) begin
            bus.op_from_op    = 3'(op);
            bus.start_from_op = 1'b1;
            @(posedge clk); #1;
            bus.start_from_op = 1'b0;
            @(negedge clk);
            check($sformatf("invalid_op%0d_busy", op), int'(bus.busy_to_op), 0);
        end

        // table-driven orders, back to back
        for (int i = 0; i < 13; i++) run_vec(i, vt[i]);

        // abort and start in the same cycle: abort wins
        bus.op_from_op        = 3'd0;
        bus.start_from_op     = 1'b1;
        bus.clear_a_from_pu   = 1'b1;
        @(posedge clk); #1;
        bus.start_from_op     = 1'b0;
        bus.clear_a_from_pu   = 1'b0;
        @(negedge clk);
        check("clear_with_start_busy", int'(bus.busy_to_op), 0);

        // mul aborted in iteration 10; a start while busy must be ignored
        answers = 0;
        bus.op_from_op     = 3'd2;
        bus.sign_a_from_au = 1'b1;
        bus.sign_b_from_au = 1'b0;
        bus.start_from_op  = 1'b1;
        model_sign = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            @(posedge clk); #1;
            bus.start_from_op   = (c == 3);
            bus.op_from_op      = (c == 3) ? 3'd0 : 3'd2;
            bus.clear_a_from_pu = (c == 22);
            @(negedge clk);
            if (bus.au_answer_to_op === 1'b1) answers++;
            if (c == 21) check("mul_busy_before_clear", int'(bus.busy_to_op), 1);
        end
        @(posedge clk); #1;
        bus.clear_a_from_pu = 1'b0;
        @(negedge clk);
        check("clear_busy_next", int'(bus.busy_to_op), 0);
        check("clear_cnt", int'(dut.cnt_r), 0);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.au_answer_to_op === 1'b1) answers++;
        end
        check("clear_no_answer", answers, 0);
        check("clear_sign_held", int'(bus.result_sign_to_au), 1);
        run_vec(20, vt[1]);

        // asynchronous reset in the middle of a mul
        answers = 0;
        bus.op_from_op     = 3'd2;
        bus.sign_a_from_au = 1'b1;
        bus.sign_b_from_au = 1'b0;
        bus.start_from_op  = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            bus.start_from_op = 1'b0;
            @(negedge clk);
        end
        #2;
        resetn = 1'b0;
        #1;
        check("async_reset_busy", int'(bus.busy_to_op), 0);
        check("async_reset_sign", int'(bus.result_sign_to_au), 0);
        check("async_reset_cnt", int'(dut.cnt_r), 0);
        model_sign = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.au_answer_to_op === 1'b1) answers++;
        end
        check("async_reset_no_answer", answers, 0);
        run_vec(21, vt[4]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
